// File: rtl/ch_event_counter_array.sv
// Multi-channel event counter with an RTC-gated measurement window.
// Each channel counts synchronised rising edges. When the window closes, the
// counts are snapshotted and shifted out serially, one word per channel,
// with a load strobe, channel address and overflow flags.

// One channel: input synchroniser, edge detect and live counter.
// cnt_nxt_o/ovf_nxt_o carry the value including this cycle's edge, so the
// snapshot taken in the window-closing cycle sees an edge in that cycle.
module ch_event_counter_lane #(
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             ch_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             ovf_nxt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    assign rise = en_i & s2_q & ~s3_q;

    // Two-flop synchroniser plus edge-history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ch_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Next count: increment on an edge, wrap or saturate at max
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rise) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Live counter: held at zero while disabled, cleared after window close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (!en_i || clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_nxt_o = cnt_d;
    assign ovf_nxt_o = ovf_d;
endmodule

module ch_event_counter_array #(
    parameter int N_CH      = 8,
    parameter int CNT_W     = 8,
    parameter int AW        = 4,
    parameter int RTC_TICKS = 4,
    parameter int SATURATE  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] ch,
    input  logic            rtc,
    output logic            serial_out,
    output logic            sl,
    output logic [AW-1:0]   addr,
    output logic            ovf_ch_out,
    output logic            ovf_global,
    output logic            ovf_rtc,
    output logic            busy
);
    localparam int TW = (RTC_TICKS > 1) ? $clog2(RTC_TICKS) : 1;
    localparam int BW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int KW = $clog2(N_CH);
    localparam logic [TW-1:0] TICK_LAST = TW'(RTC_TICKS - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(CNT_W - 1);
    localparam logic [AW-1:0] K_LAST    = AW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic                       rtc_s1_q, rtc_s2_q, rtc_s3_q;
    logic                       rtc_rise, win_close;
    logic [TW-1:0]              tick_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_nxt;
    logic [N_CH-1:0]            ovf_nxt;

    state_t                     state_q;
    logic [AW-1:0]              k_q, k_inc;
    logic [KW-1:0]              k_idx, k_inc_idx;
    logic [BW-1:0]              bit_q, bit_dec;
    logic [N_CH-1:0][CNT_W-1:0] snap_cnt_q;
    logic [N_CH-1:0]            snap_ovf_q;
    logic                       ser_q, sl_q, ovf_ch_q, glb_q, rtc_ovf_q, busy_q;

    assign rtc_rise  = en & rtc_s2_q & ~rtc_s3_q;
    assign win_close = rtc_rise && (tick_q == TICK_LAST);

    // RTC synchroniser and edge-history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtc_s1_q <= 1'b0;
            rtc_s2_q <= 1'b0;
            rtc_s3_q <= 1'b0;
        end else begin
            rtc_s1_q <= rtc;
            rtc_s2_q <= rtc_s1_q;
            rtc_s3_q <= rtc_s2_q;
        end
    end

    // Tick counter: counts RTC edges, restarts when the window closes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else if (!en || win_close) begin
            tick_q <= '0;
        end else if (rtc_rise) begin
            tick_q <= tick_q + TW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        ch_event_counter_lane #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en_i      (en),
            .ch_i      (ch[g]),
            .clr_i     (win_close),
            .cnt_nxt_o (cnt_nxt[g]),
            .ovf_nxt_o (ovf_nxt[g])
        );
    end

    assign k_inc     = k_q + AW'(1);
    assign k_idx     = k_q[KW-1:0];
    assign k_inc_idx = k_inc[KW-1:0];
    assign bit_dec   = bit_q - BW'(1);

    // Readout FSM; outputs are registered alongside the state so each
    // output reflects the state it is entering
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            bit_q      <= '0;
            snap_cnt_q <= '0;
            snap_ovf_q <= '0;
            ser_q      <= 1'b0;
            sl_q       <= 1'b0;
            ovf_ch_q   <= 1'b0;
            glb_q      <= 1'b0;
            rtc_ovf_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (win_close && state_q != IDLE)
                rtc_ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (win_close) begin
                        snap_cnt_q <= cnt_nxt;
                        snap_ovf_q <= ovf_nxt;
                        glb_q      <= |ovf_nxt;
                        k_q        <= '0;
                        state_q    <= LOAD;
                        sl_q       <= 1'b1;
                        ovf_ch_q   <= ovf_nxt[0];
                        ser_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                    bit_q   <= BIT_TOP;
                    sl_q    <= 1'b0;
                    ser_q   <= snap_cnt_q[k_idx][BIT_TOP];
                end
                SHIFT: begin
                    if (bit_q == '0) begin
                        ser_q <= 1'b0;
                        if (k_q == K_LAST) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            ovf_ch_q <= 1'b0;
                            k_q      <= '0;
                        end else begin
                            state_q  <= LOAD;
                            k_q      <= k_inc;
                            sl_q     <= 1'b1;
                            ovf_ch_q <= snap_ovf_q[k_inc_idx];
                        end
                    end else begin
                        bit_q <= bit_dec;
                        ser_q <= snap_cnt_q[k_idx][bit_dec];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_out = ser_q;
    assign sl         = sl_q;
    assign addr       = k_q;
    assign ovf_ch_out = ovf_ch_q;
    assign ovf_global = glb_q;
    assign ovf_rtc    = rtc_ovf_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_ch_event_counter_array.sv
// Bench for ch_event_counter_array: three instances (defaults, saturating,
// one-tick window) share stimulus; a window-level model predicts the full
// output stream, and directed literal checks pin the model.
module tb_ch_event_counter_array;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       rtc = 1'b0;
    logic [7:0] ch = '0;
    logic [2:0] so, slw, ovc, og, orc, bs;
    logic [3:0] ad [3];

    always #5 clk = ~clk;

    ch_event_counter_array u0 (
        .clk(clk), .reset(reset), .en(en), .ch(ch), .rtc(rtc),
        .serial_out(so[0]), .sl(slw[0]), .addr(ad[0]), .ovf_ch_out(ovc[0]),
        .ovf_global(og[0]), .ovf_rtc(orc[0]), .busy(bs[0]));
    ch_event_counter_array #(.SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .ch(ch), .rtc(rtc),
        .serial_out(so[1]), .sl(slw[1]), .addr(ad[1]), .ovf_ch_out(ovc[1]),
        .ovf_global(og[1]), .ovf_rtc(orc[1]), .busy(bs[1]));
    ch_event_counter_array #(.RTC_TICKS(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .ch(ch), .rtc(rtc),
        .serial_out(so[2]), .sl(slw[2]), .addr(ad[2]), .ovf_ch_out(ovc[2]),
        .ovf_global(og[2]), .ovf_rtc(orc[2]), .busy(bs[2]));

    typedef struct packed {
        logic       sl;
        logic [3:0] addr;
        logic       ovfch;
        logic       ser;
        logic       busy;
    } exp_t;

    function automatic int tk(int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic bit sat(int i);
        return (i == 1);
    endfunction

    // ---------------- model state ----------------
    int         cntm [3][8];
    logic [7:0] ovfm [3];
    int         tickm [3];
    exp_t       curm [3];
    exp_t       mq [3][$];
    logic [2:0] mglb, mrtc;
    logic [7:0] hc [4];
    logic [3:0] hr;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 8; c++) cntm[i][c] = 0;
            ovfm[i] = '0;
            tickm[i] = 0;
            curm[i] = '0;
            mq[i].delete();
        end
        mglb = '0;
        mrtc = '0;
        for (int j = 0; j < 4; j++) hc[j] = '0;
        hr = '0;
    endtask

    // An input level sampled at clock p is counted as an edge at clock p+2.
    task automatic model_clock();
        logic [7:0] ev;
        logic       rv, close;
        logic [7:0] w;
        exp_t       e;
        hc[3] = hc[2]; hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = ch;
        hr = {hr[2:0], rtc};
        ev = en ? (hc[2] & ~hc[3]) : 8'h00;
        rv = en & hr[2] & ~hr[3];
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 8; c++) begin
                if (ev[c]) begin
                    if (cntm[i][c] == 255) begin
                        ovfm[i][c] = 1'b1;
                        cntm[i][c] = sat(i) ? 255 : 0;
                    end else begin
                        cntm[i][c]++;
                    end
                end
            end
            close = rv && (tickm[i] == tk(i) - 1);
            if (close) begin
                if (curm[i].busy) begin
                    mrtc[i] = 1'b1;
                end else begin
                    mglb[i] = |ovfm[i];
                    for (int k = 0; k < 8; k++) begin
                        w = 8'(cntm[i][k]);
                        e = '0;
                        e.sl = 1'b1; e.addr = 4'(k); e.ovfch = ovfm[i][k]; e.busy = 1'b1;
                        mq[i].push_back(e);
                        for (int b = 7; b >= 0; b--) begin
                            e.sl = 1'b0;
                            e.ser = w[b];
                            mq[i].push_back(e);
                        end
                    end
                end
            end
            curm[i] = (mq[i].size() > 0) ? mq[i].pop_front() : '0;
            if (!en || close) begin
                for (int c = 0; c < 8; c++) cntm[i][c] = 0;
                ovfm[i] = '0;
                tickm[i] = 0;
            end else if (rv) begin
                tickm[i]++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_clock();
        end
    end

    // ---------------- checking and collection ----------------
    int         nerr = 0;
    int         nchk = 0;
    int         bcnt [3], cadr [3], run [3], lastrun [3], slc [3];
    logic [7:0] acc [3];
    logic [7:0] wc [3][8];
    logic       oc [3][8];

    task automatic chk(string n, int got, int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [9:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            got = {slw[i], ad[i], ovc[i], so[i], bs[i], og[i], orc[i]};
            exp = {curm[i].sl, curm[i].addr, curm[i].ovfch, curm[i].ser, curm[i].busy,
                   mglb[i], mrtc[i]};
            nchk++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL stream u%0d t=%0t got %b expected %b", i, $time, got, exp);
            end
            if (slw[i]) begin
                cadr[i] = int'(ad[i]) & 7;
                bcnt[i] = 8;
                acc[i] = '0;
                oc[i][cadr[i]] = ovc[i];
                slc[i]++;
            end else if (bcnt[i] > 0) begin
                acc[i] = {acc[i][6:0], so[i]};
                bcnt[i]--;
                if (bcnt[i] == 0) wc[i][cadr[i]] = acc[i];
            end
            if (bs[i]) run[i]++;
            else if (run[i] > 0) begin
                lastrun[i] = run[i];
                run[i] = 0;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
    endtask
    task automatic run_n(int n);
        repeat (n) cyc();
    endtask
    task automatic pulse(int c, int n);
        repeat (n) begin
            ch[c] = 1'b1; run_n(2);
            ch[c] = 1'b0; run_n(2);
        end
    endtask
    task automatic rtc_edges(int n);
        repeat (n) begin
            rtc = 1'b1; run_n(3);
            rtc = 1'b0; run_n(3);
        end
    endtask
    task automatic wait_done(int i);
        int n = 0;
        while (bs[i] && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) begin
            nchk++;
            nerr++;
            $display("FAIL timeout u%0d busy still %0d expected 0", i, bs[i]);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base, n, sum;
        for (int i = 0; i < 3; i++) begin
            bcnt[i] = 0; cadr[i] = 0; run[i] = 0; lastrun[i] = 0; slc[i] = 0; acc[i] = '0;
            for (int k = 0; k < 8; k++) begin
                wc[i][k] = '0;
                oc[i][k] = 1'b0;
            end
        end

        // Reset with all channels high and RTC toggling
        reset = 1'b1; ch = 8'hFF; en = 1'b1;
        repeat (6) begin
            rtc = ~rtc;
            cyc();
        end
        chk("reset_outs_u0", int'({so[0], slw[0], ad[0], ovc[0], og[0], orc[0], bs[0]}), 0);
        chk("reset_outs_u2", int'({so[2], slw[2], ad[2], ovc[2], og[2], orc[2], bs[2]}), 0);
        rtc = 1'b0; cyc();
        reset = 1'b0; run_n(2);
        ch = 8'h00; run_n(4);
        base = slc[0];
        rtc_edges(3); run_n(4);
        chk("no_sl_before_4_ticks", slc[0] - base, 0);
        rtc_edges(1);
        wait_done(0);
        chk("post_reset_edge_ch4", int'(wc[0][4]), 1);

        // Basic count
        pulse(0, 5);
        pulse(7, 3);
        base = slc[0];
        rtc_edges(4);
        wait_done(0);
        chk("basic_word0", int'(wc[0][0]), 5);
        chk("basic_word7", int'(wc[0][7]), 3);
        chk("basic_word3", int'(wc[0][3]), 0);
        chk("basic_sl_count", slc[0] - base, 8);
        chk("basic_busy_len", lastrun[0], 72);
        chk("basic_ovfch0", int'(oc[0][0]), 0);
        chk("basic_ovf_global", int'(og[0]), 0);

        // Overflow: wrap (u0) and saturate (u1)
        pulse(2, 260);
        rtc_edges(4);
        wait_done(0);
        wait_done(1);
        chk("wrap_word2", int'(wc[0][2]), 4);
        chk("wrap_ovfch2", int'(oc[0][2]), 1);
        chk("wrap_ovfch1", int'(oc[0][1]), 0);
        chk("wrap_ovf_global", int'(og[0]), 1);
        chk("sat_word2", int'(wc[1][2]), 255);
        chk("sat_ovfch2", int'(oc[1][2]), 1);
        chk("sat_ovf_global", int'(og[1]), 1);

        // Edge in the closing cycle T (ch1) and in T+1 (ch3)
        rtc_edges(3);
        rtc = 1'b1; ch[1] = 1'b1; run_n(1);
        ch[3] = 1'b1; run_n(2);
        rtc = 1'b0; ch[1] = 1'b0; run_n(1);
        ch[3] = 1'b0; run_n(3);
        wait_done(0);
        chk("edge_in_T_ch1", int'(wc[0][1]), 1);
        chk("edge_in_T1_ch3_not_yet", int'(wc[0][3]), 0);
        rtc_edges(4);
        wait_done(0);
        chk("edge_in_T1_ch3_next", int'(wc[0][3]), 1);
        chk("edge_in_T_ch1_next", int'(wc[0][1]), 0);

        // en=0 for a whole window
        en = 1'b0;
        pulse(0, 3);
        base = slc[0];
        rtc_edges(4);
        run_n(4);
        chk("en0_no_sl", slc[0] - base, 0);
        en = 1'b1; run_n(3);
        rtc_edges(4);
        wait_done(0);
        sum = 0;
        for (int k = 0; k < 8; k++) sum += int'(wc[0][k]);
        chk("en0_all_zero", sum, 0);

        // Reset at cycle 20 of a readout
        pulse(6, 2);
        rtc_edges(3);
        rtc = 1'b1;
        n = 0;
        while (!bs[0] && n < 50) begin
            cyc();
            n++;
        end
        chk("mid_busy_started", int'(bs[0]), 1);
        rtc = 1'b0;
        run_n(19);
        #1 reset = 1'b1; rtc = 1'b0; ch = 8'h00;
        #1 chk("mid_reset_outs", int'({so[0], slw[0], ad[0], ovc[0], og[0], orc[0], bs[0]}), 0);
        cyc(); cyc();
        reset = 1'b0; run_n(3);

        // Overrun on the one-tick instance; fresh counts on u0 after reset
        pulse(6, 1);
        chk("u2_ovr_clear", int'(orc[2]), 0);
        rtc = 1'b1; run_n(3);
        rtc = 1'b0; run_n(37);
        chk("u2_busy_at_40", int'(bs[2]), 1);
        chk("u2_no_ovr_yet", int'(orc[2]), 0);
        rtc = 1'b1; run_n(3);
        rtc = 1'b0; run_n(3);
        chk("u2_overrun_set", int'(orc[2]), 1);
        wait_done(2);
        chk("u2_first_word6", int'(wc[2][6]), 1);
        chk("u2_first_word5", int'(wc[2][5]), 0);
        rtc_edges(2);
        wait_done(0);
        chk("fresh_word6", int'(wc[0][6]), 1);
        chk("u0_no_overrun", int'(orc[0]), 0);
        chk("u2_overrun_sticky", int'(orc[2]), 1);
        run_n(5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
